// File: rtl/fft16_r4_stream_if.sv
// rtl/fft16_r4_stream_if.sv - sample-in / spectrum-out handshake bundle for the 16-point FFT engine
interface fft16_r4_stream_if #(
  parameter int DATA_W = 17
);
  logic                in_valid;
  logic                in_ready;
  logic                in_inv;
  logic [8*DATA_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [8*DATA_W-1:0] out_data;
  logic                out_ovf;

  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fft16_r4_stream.sv
// rtl/fft16_r4_stream.sv - streaming 16-point radix-4 FFT/IFFT with internal 4x4 transpose buffer
// Frames enter as 4 beats of x[4j+b] and leave as 4 beats of X[k1+4j].
module fft16_r4_stream #(
  parameter int DATA_W    = 17,
  parameter int COEF_FRAC = 8,
  parameter int SCALE     = 0
) (
  input logic              clk,
  input logic              rst,
  fft16_r4_stream_if.slave s
);
  localparam int BW = DATA_W + 3;
  localparam int CW = COEF_FRAC + 2;
  localparam int PW = BW + CW + 1;

  typedef logic signed [BW-1:0] wide_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic [2*DATA_W-1:0]  cplx_t;
  typedef enum logic {ST_LOAD, ST_OUT} state_e;

  localparam coef_t K_C1 = CW'($rtoi(0.92387953251 * (2.0 ** COEF_FRAC) + 0.5));
  localparam coef_t K_S1 = CW'($rtoi(0.38268343237 * (2.0 ** COEF_FRAC) + 0.5));
  localparam coef_t K_R2 = CW'($rtoi(0.70710678119 * (2.0 ** COEF_FRAC) + 0.5));
  localparam prod_t RND  = PW'(1) <<< (COEF_FRAC - 1);
  localparam prod_t MAXV = (PW'(1) <<< (DATA_W - 1)) - PW'(1);
  localparam prod_t MINV = -(PW'(1) <<< (DATA_W - 1));

  state_e state_q, state_d;
  logic [1:0] b_q, b_d;
  logic [1:0] k1_q, k1_d;
  logic       inv_q, inv_d;
  logic       sticky_q, sticky_d;
  cplx_t      buf_q [4][4];
  cplx_t      row_d [4];
  logic       cur_inv;
  logic       sat1, sat2;
  logic       in_ready_c, out_valid_c;
  logic       in_fire, out_fire;
  logic [8*DATA_W-1:0] out_data_c;

  function automatic logic is_ovf(input prod_t v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic [DATA_W-1:0] clip(input prod_t v);
    if (v > MAXV) return MAXV[DATA_W-1:0];
    if (v < MINV) return MINV[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  // Y[k] = sum a[n] * (-j)^(n*k); the extra headroom bit covers a negated most-negative input
  function automatic void bfly(input wide_t ar [4], input wide_t ai [4],
                               output wide_t yr [4], output wide_t yi [4]);
    yr[0] = ar[0] + ar[1] + ar[2] + ar[3];
    yi[0] = ai[0] + ai[1] + ai[2] + ai[3];
    yr[1] = ar[0] + ai[1] - ar[2] - ai[3];
    yi[1] = ai[0] - ar[1] - ai[2] + ar[3];
    yr[2] = ar[0] - ar[1] + ar[2] - ar[3];
    yi[2] = ai[0] - ai[1] + ai[2] - ai[3];
    yr[3] = ar[0] - ai[1] - ar[2] + ai[3];
    yi[3] = ai[0] + ar[1] - ai[2] - ar[3];
    if (SCALE != 0) begin
      for (int k = 0; k < 4; k++) begin
        yr[k] = (yr[k] + BW'(2)) >>> 2;
        yi[k] = (yi[k] + BW'(2)) >>> 2;
      end
    end
  endfunction

  // Returns {saturated, re, im} of (re + j*im) * W16^e, with W = c + j*sn
  function automatic logic [2*DATA_W:0] twiddle(input wide_t re, input wide_t im,
                                                input logic [3:0] e);
    coef_t c;
    coef_t sn;
    prod_t pr;
    prod_t pi;
    c  = '0;
    sn = '0;
    case (e)
      4'd1:    begin c = K_C1;  sn = -K_S1; end
      4'd2:    begin c = K_R2;  sn = -K_R2; end
      4'd3:    begin c = K_S1;  sn = -K_C1; end
      4'd6:    begin c = -K_R2; sn = -K_R2; end
      4'd9:    begin c = -K_C1; sn = K_S1;  end
      default: ;
    endcase
    if (e == 4'd0) begin
      pr = PW'(re);
      pi = PW'(im);
    end else if (e == 4'd4) begin
      pr = PW'(im);
      pi = -PW'(re);
    end else begin
      pr = (PW'(re) * PW'(c) - PW'(im) * PW'(sn) + RND) >>> COEF_FRAC;
      pi = (PW'(re) * PW'(sn) + PW'(im) * PW'(c) + RND) >>> COEF_FRAC;
    end
    return {is_ovf(pr) | is_ovf(pi), clip(pr), clip(pi)};
  endfunction

  always_comb begin : stage1
    wide_t ar [4];
    wide_t ai [4];
    wide_t yr [4];
    wide_t yi [4];
    logic [2*DATA_W:0] t;
    logic [3:0]        e;
    cur_inv = (b_q == 2'd0) ? s.in_inv : inv_q;
    sat1    = 1'b0;
    t       = '0;
    e       = '0;
    for (int j = 0; j < 4; j++) begin
      ar[j] = BW'($signed(s.in_data[(2*j+2)*DATA_W-1 -: DATA_W]));
      ai[j] = BW'($signed(s.in_data[(2*j+1)*DATA_W-1 -: DATA_W]));
      if (cur_inv) ai[j] = -ai[j];
    end
    bfly(ar, ai, yr, yi);
    for (int k = 0; k < 4; k++) begin
      e        = 4'(b_q) * 4'(k);
      t        = twiddle(yr[k], yi[k], e);
      row_d[k] = t[2*DATA_W-1:0];
      sat1     = sat1 | t[2*DATA_W];
    end
  end

  // Column k1 of the transpose buffer feeds the second pass
  always_comb begin : stage2
    wide_t ar [4];
    wide_t ai [4];
    wide_t yr [4];
    wide_t yi [4];
    out_data_c = '0;
    sat2       = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ar[b] = BW'($signed(buf_q[b][k1_q][2*DATA_W-1:DATA_W]));
      ai[b] = BW'($signed(buf_q[b][k1_q][DATA_W-1:0]));
    end
    bfly(ar, ai, yr, yi);
    for (int j = 0; j < 4; j++) begin
      if (inv_q) yi[j] = -yi[j];
      out_data_c[(2*j+2)*DATA_W-1 -: DATA_W] = clip(PW'(yr[j]));
      out_data_c[(2*j+1)*DATA_W-1 -: DATA_W] = clip(PW'(yi[j]));
      sat2 = sat2 | is_ovf(PW'(yr[j])) | is_ovf(PW'(yi[j]));
    end
  end

  assign in_ready_c  = !rst && (state_q == ST_LOAD);
  assign out_valid_c = !rst && (state_q == ST_OUT);
  assign in_fire     = s.in_valid && in_ready_c;
  assign out_fire    = s.out_ready && out_valid_c;

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_c;
  assign s.out_data  = out_data_c;
  assign s.out_ovf   = out_valid_c && (sticky_q || sat2);

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    k1_d     = k1_q;
    inv_d    = inv_q;
    sticky_d = sticky_q;
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          b_d = b_q + 2'd1;
          if (b_q == 2'd0) begin
            inv_d    = s.in_inv;
            sticky_d = sat1;
          end else begin
            sticky_d = sticky_q | sat1;
          end
          if (b_q == 2'd3) begin
            state_d = ST_OUT;
            k1_d    = 2'd0;
          end
        end
      end
      ST_OUT: begin
        if (out_fire) begin
          k1_d = k1_q + 2'd1;
          if (k1_q == 2'd3) begin
            state_d = ST_LOAD;
            b_d     = 2'd0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      b_q      <= 2'd0;
      k1_q     <= 2'd0;
      inv_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      k1_q     <= k1_d;
      inv_q    <= inv_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < 4; k++) begin
        buf_q[b_q][k] <= row_d[k];
      end
    end
  end
endmodule

// File: tb/tb_fft16_r4_stream.sv
// tb/tb_fft16_r4_stream.sv - directed-vector bench for the streaming 16-point FFT engine
module tb_fft16_r4_stream;
  localparam int W = 17;
  typedef logic [8*W-1:0] vec_t;

  // 256 * e^(-j*2*pi*k/16), rounded: spectrum of a unit tone at x[1]
  localparam int TONE_RE [16] = '{256, 237, 181, 98, 0, -98, -181, -237,
                                  -256, -237, -181, -98, 0, 98, 181, 237};
  localparam int TONE_IM [16] = '{0, -98, -181, -237, -256, -237, -181, -98,
                                  0, 98, 181, 237, 256, 237, 181, 98};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   x_re [16];
  int   x_im [16];
  int   e_re [16];
  int   e_im [16];
  int   s_re [16];
  logic e_ovf = 1'b0;
  logic chk_s = 1'b0;

  always #5 clk = ~clk;

  fft16_r4_stream_if #(.DATA_W(W)) bus ();
  fft16_r4_stream_if #(.DATA_W(W)) bus_s ();

  fft16_r4_stream #(.DATA_W(W), .COEF_FRAC(8), .SCALE(0)) dut (
    .clk(clk), .rst(rst), .s(bus.slave)
  );
  fft16_r4_stream #(.DATA_W(W), .COEF_FRAC(8), .SCALE(1)) dut_s (
    .clk(clk), .rst(rst), .s(bus_s.slave)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_inv    = bus.in_inv;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.out_ready = bus.out_ready;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t pack_in(input int b);
    vec_t d = '0;
    for (int j = 0; j < 4; j++) begin
      d[(2*j+2)*W-1 -: W] = W'(x_re[4*j+b]);
      d[(2*j+1)*W-1 -: W] = W'(x_im[4*j+b]);
    end
    return d;
  endfunction

  function automatic vec_t pack_out(input int k1, input bit scaled);
    vec_t d = '0;
    for (int j = 0; j < 4; j++) begin
      d[(2*j+2)*W-1 -: W] = W'(scaled ? s_re[k1+4*j] : e_re[k1+4*j]);
      d[(2*j+1)*W-1 -: W] = W'(scaled ? 0 : e_im[k1+4*j]);
    end
    return d;
  endfunction

  // kind: 0 impulse, 1 DC, 2 tone at x[1], 3 full-scale DC (saturating)
  task automatic set_frame(input int kind, input bit inv);
    for (int i = 0; i < 16; i++) begin
      x_re[i] = 0; x_im[i] = 0; e_re[i] = 0; e_im[i] = 0; s_re[i] = 0;
    end
    case (kind)
      0: begin
        x_re[0] = 256;
        for (int i = 0; i < 16; i++) e_re[i] = 256;
      end
      1: begin
        for (int i = 0; i < 16; i++) x_re[i] = 256;
        e_re[0] = 4096;
        s_re[0] = 256;
      end
      2: begin
        x_re[1] = 256;
        for (int i = 0; i < 16; i++) begin
          e_re[i] = TONE_RE[i];
          e_im[i] = inv ? -TONE_IM[i] : TONE_IM[i];
        end
      end
      default: begin
        for (int i = 0; i < 16; i++) x_re[i] = 65535;
        e_re[0] = 65535;
      end
    endcase
    e_ovf = (kind == 3);
  endtask

  task automatic send_frame(input bit stall, input bit inv0, input bit inv2, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = pack_in(b);
      bus.in_inv   = (b == 0) ? inv0 : ((b == 2) ? inv2 : 1'b0);
      for (int n = 0; n < 20 && !bus.in_ready; n++) @(negedge clk);
      check("in_ready", vec_t'(bus.in_ready), vec_t'(1'b1));
      check("pre_valid", vec_t'(bus.out_valid), vec_t'(1'b0));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_inv   = 1'b0;
    if (nbeats == 4) begin
      check("lat_valid", vec_t'(bus.out_valid), vec_t'(1'b1));
    end
  endtask

  task automatic recv_frame(input bit stall, input int nbeats);
    for (int k1 = 0; k1 < nbeats; k1++) begin
      if (stall) begin
        bus.out_ready = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check("hold_data", bus.out_data, pack_out(k1, 1'b0));
          check("hold_valid", vec_t'(bus.out_valid), vec_t'(1'b1));
          check("hold_ovf", vec_t'(bus.out_ovf), vec_t'(e_ovf));
        end
      end
      bus.out_ready = 1'b1;
      check("out_valid", vec_t'(bus.out_valid), vec_t'(1'b1));
      check("out_inready", vec_t'(bus.in_ready), vec_t'(1'b0));
      check("out_data", bus.out_data, pack_out(k1, 1'b0));
      check("out_ovf", vec_t'(bus.out_ovf), vec_t'(e_ovf));
      if (chk_s) check("scaled_data", bus_s.out_data, pack_out(k1, 1'b1));
      @(negedge clk);
    end
    if (nbeats == 4) begin
      check("back_to_load", vec_t'(bus.in_ready), vec_t'(1'b1));
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_inready", vec_t'(bus.in_ready), vec_t'(1'b0));
    check("rst_outvalid", vec_t'(bus.out_valid), vec_t'(1'b0));
    check("rst_ovf", vec_t'(bus.out_ovf), vec_t'(1'b0));
    @(negedge clk);
    check("rst_inready2", vec_t'(bus.in_ready), vec_t'(1'b0));
    check("rst_outvalid2", vec_t'(bus.out_valid), vec_t'(1'b0));
    rst = 1'b0;
    #1;
    check("post_rst_ready", vec_t'(bus.in_ready), vec_t'(1'b1));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_inready", vec_t'(bus.in_ready), vec_t'(1'b0));
    check("reset_outvalid", vec_t'(bus.out_valid), vec_t'(1'b0));
    check("reset_ovf", vec_t'(bus.out_ovf), vec_t'(1'b0));
    rst = 1'b0;
    #1;
    check("first_ready", vec_t'(bus.in_ready), vec_t'(1'b1));

    set_frame(0, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 4);
    chk_s = 1'b1;
    set_frame(1, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 4);
    chk_s = 1'b0;
    set_frame(2, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 4);
    set_frame(2, 1'b1); send_frame(1'b0, 1'b1, 1'b0, 4); recv_frame(1'b0, 4);
    set_frame(2, 1'b0); send_frame(1'b0, 1'b0, 1'b1, 4); recv_frame(1'b0, 4);

    set_frame(3, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 4);
    set_frame(0, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 4);

    for (int f = 0; f < 3; f++) begin
      set_frame(f, 1'b0); send_frame(1'b1, 1'b0, 1'b0, 4); recv_frame(1'b1, 4);
    end

    set_frame(1, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 2);
    reset_pulse();
    set_frame(0, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 4);

    set_frame(3, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 2);
    reset_pulse();
    set_frame(0, 1'b0); send_frame(1'b0, 1'b0, 1'b0, 4); recv_frame(1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
